// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: front-end sequencer for the countdown timer.
//   Debounces the start/pause buttons, runs the game FSM
//   (IDLE / RUN / PAUSED / OVER) and drives the timer's control inputs.
// Ports:
//   CLK, RESET           clock, asynchronous active-high reset
//   btn_start, btn_pause raw asynchronous push-buttons (active-high)
//   player_dead, time_up synchronous level inputs from game logic / timer
//   start_pulse          one-cycle pulse to the timer's Start input
//   pause_pulse          one-cycle pulse to the timer's pause input
//   game_over            high while state is OVER
//   state_o              00 IDLE, 01 RUN, 10 PAUSED, 11 OVER
//   round_cnt            rounds started, wraps modulo 256

// Button debouncer: 2-flop synchroniser, stability counter, rising-edge press.
module game_flow_debounce #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn_raw,
  output logic press
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d, deb_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A level change is accepted only after DEB_CYCLES consecutive clocks of
  // disagreement; any return to the accepted level restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  // Only a 0->1 transition of the debounced level counts as a press.
  assign press = deb_q & ~deb_dly_q;
endmodule

module game_flow_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       player_dead,
  input  logic       time_up,
  output logic       start_pulse,
  output logic       pause_pulse,
  output logic       game_over,
  output logic [1:0] state_o,
  output logic [7:0] round_cnt
);
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    OVER   = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic       start_pulse_q, start_pulse_d;
  logic       pause_pulse_q, pause_pulse_d;
  logic       game_over_q, game_over_d;
  logic [7:0] round_cnt_q, round_cnt_d;
  logic       start_press, pause_press;

  game_flow_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_start (
    .CLK     (CLK),
    .RESET   (RESET),
    .btn_raw (btn_start),
    .press   (start_press)
  );

  game_flow_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_pause (
    .CLK     (CLK),
    .RESET   (RESET),
    .btn_raw (btn_pause),
    .press   (pause_press)
  );

  always_comb begin
    state_d       = state_q;
    start_pulse_d = 1'b0;
    pause_pulse_d = 1'b0;
    round_cnt_d   = round_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_press) begin
          state_d       = RUN;
          start_pulse_d = 1'b1;
          round_cnt_d   = round_cnt_q + 8'd1;
        end
      end
      RUN: begin
        // Losing the game outranks a pause request in the same cycle.
        if (time_up || player_dead) begin
          state_d = OVER;
        end else if (pause_press) begin
          state_d       = PAUSED;
          pause_pulse_d = 1'b1;
        end
      end
      PAUSED: begin
        if (time_up || player_dead) begin
          state_d = OVER;
        end else if (start_press || pause_press) begin
          state_d       = RUN;
          start_pulse_d = 1'b1;
        end
      end
      OVER: begin
        // Start pulse here sends the timer back to its init state.
        if (start_press) begin
          state_d       = IDLE;
          start_pulse_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered from the next state so it tracks state_q exactly.
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      start_pulse_q <= 1'b0;
      pause_pulse_q <= 1'b0;
      game_over_q   <= 1'b0;
      round_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      start_pulse_q <= start_pulse_d;
      pause_pulse_q <= pause_pulse_d;
      game_over_q   <= game_over_d;
      round_cnt_q   <= round_cnt_d;
    end
  end

  assign start_pulse = start_pulse_q;
  assign pause_pulse = pause_pulse_q;
  assign game_over   = game_over_q;
  assign state_o     = state_q;
  assign round_cnt   = round_cnt_q;
endmodule
